bram_vector_writer: RTL and testbench
=====================================

// Module: bram_vector_writer
// PURPOSE
//  Write-side counterpart of the layer weight/activation loaders.
//  On start, snapshots a flat vector of NUM_WORDS words of W bits each and writes it to the shared BRAM port.
//  Writes go one word per cycle, from BASE_ADDR upward.
//  Optionally reads the region back and compares it to the snapshot, flagging the first mismatching address.
//  Sits between a layer's output register file and the BRAM, so results can be stored for the next layer's loader.
// PARAMETERS
//  NUM_WORDS   128  words per transfer (>=1)
//  W           8    word width, bits
//  ADDR_WIDTH  18   BRAM address width
//  BASE_ADDR   0    first BRAM address written
//  VERIFY      1    1 = read-back compare after the write pass; 0 = skip
//  RD_LATENCY  2    BRAM read latency, cycles from addr/ren to valid dout (>=1)
// PORTS
//  clk        in   1                 system clock, all logic on posedge
//  rst        in   1                 synchronous, active-high reset
//  start      in   1                 begin a transfer; sampled only in IDLE
//  data_in    in   NUM_WORDS*W       flat vector; word i = data_in[i*W +: W]; captured on accepted start
//  bram_en    out  1                 BRAM enable
//  bram_wen   out  1                 BRAM write enable
//  bram_ren   out  1                 BRAM read enable
//  bram_addr  out  ADDR_WIDTH        BRAM address
//  bram_din   out  W                 BRAM write data
//  bram_dout  in   W                 BRAM read data, valid RD_LATENCY cycles after ren/addr
//  busy       out  1                 high in WRITE/VERIFY/DONE
//  done       out  1                 one-cycle pulse at end of transfer
//  error      out  1                 read-back mismatch seen; held until next accepted start
//  err_addr   out  ADDR_WIDTH        address of the first mismatch; held with error
// BEHAVIOUR
//  Reset (rst=1 at posedge): state=IDLE.
//   Outputs: all bram_* = 0, busy = done = error = 0, err_addr = 0. Snapshot register is not cleared.
//   Reset mid-transfer aborts immediately; no further BRAM accesses; partial writes stay in the BRAM.
//  FSM IDLE -> WRITE -> (VERIFY if VERIFY=1) -> DONE -> IDLE.
//  IDLE: start=1 at edge E0 -> capture data_in, idx=0, clear error/err_addr, go to WRITE.
//   start=0 keeps IDLE.
//  WRITE: cycles 1..NUM_WORDS after E0.
//   bram_en=bram_wen=1, bram_ren=0, bram_addr=BASE_ADDR+idx, bram_din=word[idx].
//   After idx=NUM_WORDS-1, go to VERIFY (idx reset to 0) or DONE.
//  VERIFY: issue phase, then drain phase.
//   Issue phase, NUM_WORDS cycles: bram_en=bram_ren=1, wen=0, addr=BASE_ADDR+idx.
//   Drain phase: RD_LATENCY cycles, bram_en=1, ren=0, so the last read returns.
//   A RD_LATENCY-deep valid/index delay line aligns each bram_dout with its snapshot word.
//   On the first compare with bram_dout != word[k]: error<=1, err_addr<=BASE_ADDR+k. Later mismatches are ignored.
//  DONE: one cycle. done=1, busy=1, bram_* = 0. Next cycle returns to IDLE.
//  Latency, E0 -> done-high cycle:
//   NUM_WORDS+1 with VERIFY=0
//   2*NUM_WORDS+RD_LATENCY+1 with VERIFY=1
//  start while busy: ignored, not queued. start held high: a new transfer is accepted on the first IDLE edge.
//  data_in changes after E0 have no effect on the current transfer.
//  Address arithmetic is modulo 2^ADDR_WIDTH. A region that crosses the top of the address space wraps to 0; legal but not recommended.
//  NUM_WORDS=1: a single write cycle; VERIFY then takes 1+RD_LATENCY cycles.
//  idx counter width is $clog2(NUM_WORDS+1). No combinational path from inputs to outputs except through registers.
// STRUCTURE
//  Shared package, nn_mem_pkg: FSM state encoding.
//   Also holds BRAM_RD_LATENCY (2) and the per-layer base-address constants; instances take BASE_ADDR from these.
//   Layer base constants, e.g. L2_WEIGHT_BASE=147584; add an L1_ACT_BASE.
//  One sub-module: rd_compare_pipe, the RD_LATENCY-deep valid+index shift register feeding the comparator.
//  The BRAM is NOT instantiated here. Ports go to the top-level BRAM / port arbiter.
// TESTING (bench models BRAM with RD_LATENCY=2 and read-during-write = old data)
//  1. NUM_WORDS=4, BASE=100, data words 0x11,0x22,0x33,0x44, VERIFY=0, start pulse.
//     Expect writes at addr 100..103 in cycles 1..4, done on cycle 5, error=0.
//  2. Same transfer with VERIFY=1.
//     Expect reads at addr 100..103 in cycles 5..8, done on cycle 11, error=0.
//  3. VERIFY=1, bench corrupts addr 102 to 0xFF after its write.
//     Expect error=1 and err_addr=102 at done; the error is still held 5 cycles after done.
//  4. rst=1 asserted at write cycle 2.
//     Expect bram_en=0 from the next cycle, busy=0, no done, addr 102/103 never written.
//  5. Extra start pulses mid-transfer, and data_in changed to 0 mid-transfer.
//     Expect a single done; the BRAM holds the original words.
//  6. NUM_WORDS=1, BASE=2^18-1.
//     Expect one write at 0x3FFFF, done on cycle 2 (VERIFY=0).

Source files
------------

// File: rtl/nn_mem_pkg.sv
// Shared BRAM-side definitions for the layer loaders and writers:
// FSM encoding, BRAM timing and per-layer base addresses.
package nn_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WRITE  = 2'd1,
        ST_VERIFY = 2'd2,
        ST_DONE   = 2'd3
    } mem_wr_state_e;

    localparam int unsigned BRAM_RD_LATENCY = 2;
    localparam int unsigned BRAM_ADDR_WIDTH = 18;

    // Layer regions in the shared BRAM address space
    localparam logic [BRAM_ADDR_WIDTH-1:0] L1_WEIGHT_BASE = 18'd0;
    localparam logic [BRAM_ADDR_WIDTH-1:0] L2_WEIGHT_BASE = 18'd147584;
    localparam logic [BRAM_ADDR_WIDTH-1:0] L1_ACT_BASE    = 18'd196608;

endpackage

// File: rtl/rd_compare_pipe.sv
// Valid + word-index delay line that lines each BRAM read result up with
// the snapshot word it should be compared against.
module rd_compare_pipe #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned IDX_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic [IDX_W-1:0] idx_in,
    output logic             valid_out,
    output logic [IDX_W-1:0] idx_out
);

    logic [DEPTH-1:0] valid_q;
    logic [IDX_W-1:0] idx_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q[0] <= valid_in;
            for (int i = 1; i < int'(DEPTH); i++) begin
                valid_q[i] <= valid_q[i-1];
            end
        end
    end

    // Index payload only matters when its valid bit is set, so it is not reset
    always_ff @(posedge clk) begin
        idx_q[0] <= idx_in;
        for (int i = 1; i < int'(DEPTH); i++) begin
            idx_q[i] <= idx_q[i-1];
        end
    end

    assign valid_out = valid_q[DEPTH-1];
    assign idx_out   = idx_q[DEPTH-1];

endmodule

// File: rtl/bram_vector_writer.sv
// Snapshots a flat output vector, writes it to BRAM one word per cycle from
// BASE_ADDR upward, and optionally reads it back to flag the first mismatch.
module bram_vector_writer
    import nn_mem_pkg::*;
#(
    parameter int unsigned             NUM_WORDS  = 128,
    parameter int unsigned             W          = 8,
    parameter int unsigned             ADDR_WIDTH = 18,
    parameter logic [ADDR_WIDTH-1:0]   BASE_ADDR  = '0,
    parameter bit                      VERIFY     = 1'b1,
    parameter int unsigned             RD_LATENCY = BRAM_RD_LATENCY
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [NUM_WORDS*W-1:0] data_in,
    output logic                   bram_en,
    output logic                   bram_wen,
    output logic                   bram_ren,
    output logic [ADDR_WIDTH-1:0]  bram_addr,
    output logic [W-1:0]           bram_din,
    input  logic [W-1:0]           bram_dout,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [ADDR_WIDTH-1:0]  err_addr
);

    localparam int unsigned IDX_W = $clog2(NUM_WORDS + 1);
    localparam int unsigned SEL_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int unsigned DRN_W = $clog2(RD_LATENCY + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
    localparam logic [DRN_W-1:0] LAST_DRN = DRN_W'(RD_LATENCY - 1);

    mem_wr_state_e    state;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_nxt;
    logic [DRN_W-1:0] drn;
    logic [W-1:0]     snap [NUM_WORDS];

    logic             cmp_valid;
    logic [IDX_W-1:0] cmp_idx;
    logic [SEL_W-1:0] cmp_sel;

    assign idx_nxt = idx + IDX_W'(1);
    assign cmp_sel = SEL_W'(cmp_idx);

    // Snapshot of the source vector, taken only on an accepted start
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && start) begin
            for (int i = 0; i < int'(NUM_WORDS); i++) begin
                snap[i] <= data_in[i*W +: W];
            end
        end
    end

    rd_compare_pipe #(
        .DEPTH (RD_LATENCY),
        .IDX_W (IDX_W)
    ) u_rd_pipe (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (bram_ren),
        .idx_in    (idx),
        .valid_out (cmp_valid),
        .idx_out   (cmp_idx)
    );

    // Transfer sequencer; BRAM controls are registered for the cycle they apply to
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            idx       <= '0;
            drn       <= '0;
            bram_en   <= 1'b0;
            bram_wen  <= 1'b0;
            bram_ren  <= 1'b0;
            bram_addr <= '0;
            bram_din  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            err_addr  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_WRITE;
                        idx       <= '0;
                        busy      <= 1'b1;
                        error     <= 1'b0;
                        err_addr  <= '0;
                        bram_en   <= 1'b1;
                        bram_wen  <= 1'b1;
                        bram_ren  <= 1'b0;
                        bram_addr <= BASE_ADDR;
                        bram_din  <= data_in[W-1:0];
                    end
                end
                ST_WRITE: begin
                    if (idx == LAST_IDX) begin
                        idx      <= '0;
                        bram_wen <= 1'b0;
                        bram_din <= '0;
                        if (VERIFY) begin
                            state     <= ST_VERIFY;
                            bram_ren  <= 1'b1;
                            bram_addr <= BASE_ADDR;
                        end else begin
                            state     <= ST_DONE;
                            bram_en   <= 1'b0;
                            bram_addr <= '0;
                            done      <= 1'b1;
                        end
                    end else begin
                        idx       <= idx_nxt;
                        bram_addr <= BASE_ADDR + ADDR_WIDTH'(idx_nxt);
                        bram_din  <= snap[SEL_W'(idx_nxt)];
                    end
                end
                ST_VERIFY: begin
                    // bram_ren high = issue phase, low = draining the read pipeline
                    if (bram_ren) begin
                        if (idx == LAST_IDX) begin
                            bram_ren <= 1'b0;
                            drn      <= '0;
                        end else begin
                            idx       <= idx_nxt;
                            bram_addr <= BASE_ADDR + ADDR_WIDTH'(idx_nxt);
                        end
                    end else if (drn == LAST_DRN) begin
                        state     <= ST_DONE;
                        bram_en   <= 1'b0;
                        bram_addr <= '0;
                        done      <= 1'b1;
                    end else begin
                        drn <= drn + DRN_W'(1);
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase

            // Only the first mismatch of a transfer is recorded
            if (cmp_valid && !error && (bram_dout != snap[cmp_sel])) begin
                error    <= 1'b1;
                err_addr <= BASE_ADDR + ADDR_WIDTH'(cmp_idx);
            end
        end
    end

endmodule

// File: tb/tb_bram_vector_writer.sv
// Bench for bram_vector_writer: three instances (write-only, verify, single
// word at the top of the address space) against a 2-cycle-latency BRAM model.
module tb_bram_vector_writer;

    localparam int unsigned AW = 18;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Write-only instance: 4 words at 100
    logic          nv_start;
    logic [31:0]   nv_data;
    logic          nv_en, nv_wen, nv_ren, nv_busy, nv_done, nv_error;
    logic [AW-1:0] nv_addr, nv_err_addr;
    logic [7:0]    nv_din;
    logic [7:0]    nv_dout = 8'h00;

    // Verifying instance: 4 words at 100, backed by the BRAM model
    logic          v_start;
    logic [31:0]   v_data;
    logic          v_en, v_wen, v_ren, v_busy, v_done, v_error;
    logic [AW-1:0] v_addr, v_err_addr;
    logic [7:0]    v_din;
    logic [7:0]    v_dout = 8'h00;

    // Single-word instance at the last address
    logic          o_start;
    logic [7:0]    o_data;
    logic          o_en, o_wen, o_ren, o_busy, o_done, o_error;
    logic [AW-1:0] o_addr, o_err_addr;
    logic [7:0]    o_din;
    logic [7:0]    o_dout = 8'h00;

    bram_vector_writer #(.NUM_WORDS(4), .W(8), .ADDR_WIDTH(AW), .BASE_ADDR(18'd100),
                         .VERIFY(1'b0), .RD_LATENCY(2)) dut_nv (
        .clk(clk), .rst(rst), .start(nv_start), .data_in(nv_data),
        .bram_en(nv_en), .bram_wen(nv_wen), .bram_ren(nv_ren), .bram_addr(nv_addr),
        .bram_din(nv_din), .bram_dout(nv_dout), .busy(nv_busy), .done(nv_done),
        .error(nv_error), .err_addr(nv_err_addr));

    bram_vector_writer #(.NUM_WORDS(4), .W(8), .ADDR_WIDTH(AW), .BASE_ADDR(18'd100),
                         .VERIFY(1'b1), .RD_LATENCY(2)) dut_v (
        .clk(clk), .rst(rst), .start(v_start), .data_in(v_data),
        .bram_en(v_en), .bram_wen(v_wen), .bram_ren(v_ren), .bram_addr(v_addr),
        .bram_din(v_din), .bram_dout(v_dout), .busy(v_busy), .done(v_done),
        .error(v_error), .err_addr(v_err_addr));

    bram_vector_writer #(.NUM_WORDS(1), .W(8), .ADDR_WIDTH(AW), .BASE_ADDR(18'h3FFFF),
                         .VERIFY(1'b0), .RD_LATENCY(2)) dut_one (
        .clk(clk), .rst(rst), .start(o_start), .data_in(o_data),
        .bram_en(o_en), .bram_wen(o_wen), .bram_ren(o_ren), .bram_addr(o_addr),
        .bram_din(o_din), .bram_dout(o_dout), .busy(o_busy), .done(o_done),
        .error(o_error), .err_addr(o_err_addr));

    // BRAM model for addresses 100..103: read latency 2, read-during-write returns old data
    logic [7:0] mem [4];
    logic [7:0] rd_s1;
    logic       crpt_req;
    logic [3:0] crpt_mask;
    logic [7:0] crpt_val [4];

    always @(posedge clk) begin
        if (v_en && v_wen && v_addr >= AW'(100) && v_addr < AW'(104))
            mem[2'(v_addr - AW'(100))] <= v_din;
        if (v_en && v_ren)
            rd_s1 <= (v_addr >= AW'(100) && v_addr < AW'(104)) ? mem[2'(v_addr - AW'(100))] : 8'h00;
        v_dout <= rd_s1;
        if (crpt_req) begin
            for (int k = 0; k < 4; k++)
                if (crpt_mask[k]) mem[k] <= crpt_val[k];
        end
    end

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({nv_en, nv_wen, nv_ren, nv_busy, nv_done, nv_error} !== 6'b0 || nv_addr !== '0 ||
            nv_din !== '0 || nv_err_addr !== '0) begin
            failures++;
            $display("FAIL reset_nv: en/wen/ren/busy/done/err=%b addr=%h din=%h ea=%h want all zero",
                     {nv_en, nv_wen, nv_ren, nv_busy, nv_done, nv_error}, nv_addr, nv_din, nv_err_addr);
        end
        checks++;
        if ({v_en, v_wen, v_ren, v_busy, v_done, v_error} !== 6'b0 || v_addr !== '0 ||
            v_din !== '0 || v_err_addr !== '0) begin
            failures++;
            $display("FAIL reset_v: en/wen/ren/busy/done/err=%b addr=%h din=%h ea=%h want all zero",
                     {v_en, v_wen, v_ren, v_busy, v_done, v_error}, v_addr, v_din, v_err_addr);
        end
        checks++;
        if ({o_en, o_wen, o_ren, o_busy, o_done, o_error} !== 6'b0 || o_addr !== '0 ||
            o_din !== '0 || o_err_addr !== '0) begin
            failures++;
            $display("FAIL reset_one: en/wen/ren/busy/done/err=%b addr=%h din=%h ea=%h want all zero",
                     {o_en, o_wen, o_ren, o_busy, o_done, o_error}, o_addr, o_din, o_err_addr);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_write_only(input logic [31:0] data);
        logic [7:0] w [4];
        logic [4:0] got, exp;
        for (int k = 0; k < 4; k++) w[k] = data[8*k +: 8];
        nv_data  = data;
        nv_start = 1'b1;
        @(posedge clk);
        #1;
        nv_start = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            exp = {c <= 4, c <= 4, 1'b0, c <= 5, c == 5};
            got = {nv_en, nv_wen, nv_ren, nv_busy, nv_done};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL wr_only_ctrl cycle %0d: en/wen/ren/busy/done got %b want %b", c, got, exp);
            end
            if (c <= 4) begin
                checks++;
                if (nv_addr !== AW'(100 + c - 1) || nv_din !== w[c-1]) begin
                    failures++;
                    $display("FAIL wr_only_data cycle %0d: addr=%0d din=%h want addr=%0d din=%h",
                             c, nv_addr, nv_din, 100 + c - 1, w[c-1]);
                end
            end
            if (c == 5) begin
                checks++;
                if (nv_error !== 1'b0 || nv_err_addr !== '0) begin
                    failures++;
                    $display("FAIL wr_only_err: error=%b ea=%0d want 0/0", nv_error, nv_err_addr);
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_verify(input logic [31:0] data, input logic [3:0] mask, input logic [31:0] cval);
        logic [7:0]    w [4];
        logic [7:0]    exp_mem [4];
        logic          exp_err;
        logic [AW-1:0] exp_ea;
        logic [4:0]    got, exp;
        exp_err = 1'b0;
        exp_ea  = '0;
        for (int k = 0; k < 4; k++) begin
            w[k]        = data[8*k +: 8];
            exp_mem[k]  = mask[k] ? cval[8*k +: 8] : w[k];
            crpt_val[k] = cval[8*k +: 8];
        end
        for (int k = 3; k >= 0; k--) begin
            if (mask[k]) begin
                exp_err = 1'b1;
                exp_ea  = AW'(100 + k);
            end
        end
        crpt_mask = mask;
        v_data    = data;
        v_start   = 1'b1;
        @(posedge clk);
        #1;
        v_start = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            crpt_req = (c == 4);
            exp = {c <= 10, c <= 4, c >= 5 && c <= 8, c <= 11, c == 11};
            got = {v_en, v_wen, v_ren, v_busy, v_done};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL verify_ctrl cycle %0d: en/wen/ren/busy/done got %b want %b", c, got, exp);
            end
            if (c <= 4) begin
                checks++;
                if (v_addr !== AW'(100 + c - 1) || v_din !== w[c-1]) begin
                    failures++;
                    $display("FAIL verify_write cycle %0d: addr=%0d din=%h want addr=%0d din=%h",
                             c, v_addr, v_din, 100 + c - 1, w[c-1]);
                end
            end else if (c <= 8) begin
                checks++;
                if (v_addr !== AW'(100 + c - 5)) begin
                    failures++;
                    $display("FAIL verify_read_addr cycle %0d: addr=%0d want %0d", c, v_addr, 100 + c - 5);
                end
            end
            if (c == 1 || c >= 11) begin
                checks++;
                if (v_error !== ((c == 1) ? 1'b0 : exp_err) || v_err_addr !== ((c == 1) ? AW'(0) : exp_ea)) begin
                    failures++;
                    $display("FAIL verify_error cycle %0d: error=%b ea=%0d want error=%b ea=%0d",
                             c, v_error, v_err_addr, (c == 1) ? 1'b0 : exp_err, (c == 1) ? AW'(0) : exp_ea);
                end
            end
            @(posedge clk);
            #1;
        end
        crpt_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (mem[k] !== exp_mem[k]) begin
                failures++;
                $display("FAIL verify_mem addr %0d: got %h want %h", 100 + k, mem[k], exp_mem[k]);
            end
        end
    endtask

    task automatic test_reset_mid_write;
        logic [7:0] old2, old3;
        int         wr_hi;
        logic [5:0] got;
        old2    = mem[2];
        old3    = mem[3];
        wr_hi   = 0;
        v_data  = {~old3, ~old2, 8'h5A, 8'hA5};
        v_start = 1'b1;
        @(posedge clk);
        #1;
        v_start = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            if (v_en && v_wen && (v_addr == AW'(102) || v_addr == AW'(103))) wr_hi++;
            rst = (c == 2);
            if (c >= 3) begin
                got = {v_en, v_wen, v_ren, v_busy, v_done, v_error};
                checks++;
                if (got !== 6'b0) begin
                    failures++;
                    $display("FAIL rst_mid cycle %0d: en/wen/ren/busy/done/err got %b want 000000", c, got);
                end
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (wr_hi != 0 || mem[2] !== old2 || mem[3] !== old3) begin
            failures++;
            $display("FAIL rst_mid_partial: writes to 102/103=%0d mem102=%h mem103=%h want 0 %h %h",
                     wr_hi, mem[2], mem[3], old2, old3);
        end
    endtask

    task automatic test_ignore_start;
        logic [31:0] data;
        int          ndone, done_c;
        data    = $urandom;
        ndone   = 0;
        done_c  = -1;
        v_data  = data;
        v_start = 1'b1;
        @(posedge clk);
        #1;
        v_start = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (c == 1) v_data = '0;
            v_start = (c == 2 || c == 6 || c == 9 || c == 11);
            if (v_done) begin
                ndone++;
                done_c = c;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (ndone != 1 || done_c != 11) begin
            failures++;
            $display("FAIL ignore_start_done: count=%0d last_cycle=%0d want 1 at 11", ndone, done_c);
        end
        checks++;
        if (v_error !== 1'b0) begin
            failures++;
            $display("FAIL ignore_start_error: error=%b want 0", v_error);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (mem[k] !== data[8*k +: 8]) begin
                failures++;
                $display("FAIL ignore_start_mem addr %0d: got %h want %h", 100 + k, mem[k], data[8*k +: 8]);
            end
        end
    endtask

    task automatic test_start_held;
        int nd, d0, d1;
        nd = 0;
        d0 = -1;
        d1 = -1;
        v_data  = $urandom;
        v_start = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 1; c <= 26; c++) begin
            if (c == 13) v_start = 1'b0;
            if (v_done) begin
                nd++;
                if (d0 < 0) d0 = c;
                else d1 = c;
            end
            if (c == 12 || c == 13) begin
                checks++;
                if (v_busy !== (c == 13)) begin
                    failures++;
                    $display("FAIL start_held_busy cycle %0d: busy=%b want %b", c, v_busy, c == 13);
                end
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (nd != 2 || d0 != 11 || d1 != 23) begin
            failures++;
            $display("FAIL start_held_done: count=%0d cycles=%0d,%0d want 2 at 11,23", nd, d0, d1);
        end
    endtask

    task automatic test_single_word;
        logic [7:0] data;
        logic [4:0] got, exp;
        int         nwr;
        data    = 8'($urandom);
        nwr     = 0;
        o_data  = data;
        o_start = 1'b1;
        @(posedge clk);
        #1;
        o_start = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            if (o_en && o_wen) nwr++;
            exp = {c == 1, c == 1, 1'b0, c <= 2, c == 2};
            got = {o_en, o_wen, o_ren, o_busy, o_done};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL single_ctrl cycle %0d: en/wen/ren/busy/done got %b want %b", c, got, exp);
            end
            if (c == 1) begin
                checks++;
                if (o_addr !== 18'h3FFFF || o_din !== data) begin
                    failures++;
                    $display("FAIL single_write: addr=%h din=%h want 3ffff %h", o_addr, o_din, data);
                end
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (nwr != 1) begin
            failures++;
            $display("FAIL single_count: writes=%0d want 1", nwr);
        end
    endtask

    initial begin
        logic [31:0] d, cv;
        logic [3:0]  m;
        nv_start  = 1'b0;
        v_start   = 1'b0;
        o_start   = 1'b0;
        nv_data   = '0;
        v_data    = '0;
        o_data    = '0;
        crpt_req  = 1'b0;
        crpt_mask = '0;
        for (int k = 0; k < 4; k++) crpt_val[k] = '0;

        test_reset;
        test_write_only(32'h44332211);
        for (int i = 0; i < 3; i++) test_write_only($urandom);
        test_verify(32'h44332211, 4'b0000, 32'h0);
        test_verify(32'h44332211, 4'b0100, 32'h00FF0000);
        for (int i = 0; i < 10; i++) begin
            d = $urandom;
            m = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'b0000;
            for (int k = 0; k < 4; k++) cv[8*k +: 8] = d[8*k +: 8] ^ 8'($urandom_range(1, 255));
            test_verify(d, m, cv);
        end
        test_reset_mid_write;
        test_ignore_start;
        test_start_held;
        test_single_word;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
